// File: rtl/note2cnt_mc_if.sv
// Note-request handshake and per-voice count/gate outputs of note2cnt_mc.
interface note2cnt_mc_if #(
  parameter int BW    = 16,
  parameter int CH    = 4,
  parameter int CH_BW = 2
) ();
  logic                note_valid_i;
  logic                note_ready_o;
  logic [7:0]          note_i;
  logic [CH_BW-1:0]    chan_i;
  logic [CH*BW-1:0]    cnt_o;
  logic [CH-1:0]       gate_o;
  logic                upd_o;
  logic [CH_BW-1:0]    upd_ch_o;

  // Converter side
  modport slave (
    input  note_valid_i, note_i, chan_i,
    output note_ready_o, cnt_o, gate_o, upd_o, upd_ch_o
  );

  // Sequencer / decoder side
  modport master (
    output note_valid_i, note_i, chan_i,
    input  note_ready_o, cnt_o, gate_o, upd_o, upd_ch_o
  );
endinterface

// File: rtl/note2cnt_mc.sv
// Multi-voice MIDI note to half-period count converter.
// A note is split into semitone and octave by repeated subtraction of 12,
// the semitone picks a base count, and the octave shifts it right with
// saturation to the output width. Each voice keeps its count until rewritten.
module note2cnt_mc #(
  parameter int BW     = 16,
  parameter int CH     = 4,
  parameter int CH_BW  = 2,
  parameter int CLK_HZ = 1_000_000
) (
  input  logic           clk_i,
  input  logic           rst_i,
  note2cnt_mc_if.slave   bus
);

  typedef enum logic [2:0] {IDLE, DIV, LUT, SHIFT, WRITE} state_t;

  // Half-period count of semitone k in MIDI octave -1 (note k, 8.1758 Hz base).
  function automatic logic [23:0] base_val(input int k);
    real f;
    f = real'(CLK_HZ) / (2.0 * 8.17580 * (2.0 ** (real'(k) / 12.0)));
    return 24'($rtoi(f + 0.5));
  endfunction

  state_t           state_reg, state_next;
  logic [6:0]       rem_reg, rem_next;
  logic [3:0]       oct_reg, oct_next;
  logic             off_reg, off_next;
  logic [CH_BW-1:0] chan_reg, chan_next;
  logic [23:0]      base_reg, base_next;
  logic [BW-1:0]    res_reg, res_next;
  logic             upd_reg;
  logic [CH_BW-1:0] upd_ch_reg;
  logic             write_en;
  logic             chan_ok;
  logic [23:0]      shifted;
  logic [23:0]      base_tab [12];

  genvar gi;

  // Base table is fixed at elaboration from the clock rate.
  generate
    for (gi = 0; gi < 12; gi++) begin : g_base
      localparam logic [23:0] BV = base_val(gi);
      assign base_tab[gi] = BV;
    end
  endgenerate

  // Zero-extend so the range check also works when CH fills the index width.
  assign chan_ok = ({1'b0, bus.chan_i} < (CH_BW+1)'(CH));

  assign bus.note_ready_o = (state_reg == IDLE);
  assign bus.upd_o        = upd_reg;
  assign bus.upd_ch_o     = upd_ch_reg;

  // Next-state and datapath decode for the conversion sequence.
  always_comb begin
    state_next = state_reg;
    rem_next   = rem_reg;
    oct_next   = oct_reg;
    off_next   = off_reg;
    chan_next  = chan_reg;
    base_next  = base_reg;
    res_next   = res_reg;
    write_en   = 1'b0;
    shifted    = base_reg >> oct_reg;
    case (state_reg)
      IDLE: begin
        // Out-of-range channels are accepted and silently dropped.
        if (bus.note_valid_i && chan_ok) begin
          rem_next   = bus.note_i[6:0];
          oct_next   = '0;
          off_next   = bus.note_i[7];
          chan_next  = bus.chan_i;
          state_next = bus.note_i[7] ? WRITE : DIV;
        end
      end
      DIV: begin
        if (rem_reg >= 7'd12) begin
          rem_next = rem_reg - 7'd12;
          oct_next = oct_reg + 4'd1;
        end else begin
          state_next = LUT;
        end
      end
      LUT: begin
        base_next  = base_tab[rem_reg[3:0]];
        state_next = SHIFT;
      end
      SHIFT: begin
        if ((shifted >> BW) != 24'd0) res_next = '1;
        else                          res_next = BW'(shifted);
        state_next = WRITE;
      end
      WRITE: begin
        write_en   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Control and datapath registers; reset aborts any conversion in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
      rem_reg   <= '0;
      oct_reg   <= '0;
      off_reg   <= 1'b0;
      chan_reg  <= '0;
      base_reg  <= '0;
      res_reg   <= '0;
    end else begin
      state_reg <= state_next;
      rem_reg   <= rem_next;
      oct_reg   <= oct_next;
      off_reg   <= off_next;
      chan_reg  <= chan_next;
      base_reg  <= base_next;
      res_reg   <= res_next;
    end
  end

  // Update strobe: one cycle wide, channel index held between strobes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      upd_reg    <= 1'b0;
      upd_ch_reg <= '0;
    end else begin
      upd_reg <= write_en;
      if (write_en) upd_ch_reg <= chan_reg;
    end
  end

  // Per-voice count and gate storage; only the addressed voice is written.
  generate
    for (gi = 0; gi < CH; gi++) begin : g_voice
      logic [BW-1:0] cnt_v_reg;
      logic          gate_v_reg;

      // Voice gi latches the result when the write targets it.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          cnt_v_reg  <= '0;
          gate_v_reg <= 1'b0;
        end else if (write_en && (chan_reg == CH_BW'(gi))) begin
          cnt_v_reg  <= off_reg ? '0 : res_reg;
          gate_v_reg <= ~off_reg;
        end
      end

      assign bus.cnt_o[gi*BW +: BW] = cnt_v_reg;
      assign bus.gate_o[gi]         = gate_v_reg;
    end
  endgenerate

endmodule

// File: tb/tb_note2cnt_mc.sv
// Self-checking bench: a 16-bit and a 12-bit converter run in lockstep on the
// same request stream and are compared against a frequency-based model.
module tb_note2cnt_mc;
  localparam int CH    = 3;
  localparam int CH_BW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  int m_cnt16 [CH];
  int m_cnt12 [CH];
  int m_gate  [CH];

  always #5 clk = ~clk;

  note2cnt_mc_if #(.BW(16), .CH(CH), .CH_BW(CH_BW)) if16 ();
  note2cnt_mc_if #(.BW(12), .CH(CH), .CH_BW(CH_BW)) if12 ();

  assign if12.note_valid_i = if16.note_valid_i;
  assign if12.note_i       = if16.note_i;
  assign if12.chan_i       = if16.chan_i;

  note2cnt_mc #(.BW(16), .CH(CH), .CH_BW(CH_BW), .CLK_HZ(1_000_000)) dut16 (
    .clk_i(clk), .rst_i(rst), .bus(if16.slave));
  note2cnt_mc #(.BW(12), .CH(CH), .CH_BW(CH_BW), .CLK_HZ(1_000_000)) dut12 (
    .clk_i(clk), .rst_i(rst), .bus(if12.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected count: oscillator frequency from the MIDI pitch formula, half period in clocks,
  // with the octave applied as an integer right shift of the rounded base count.
  function automatic int model_count(input int note, input int bw);
    real f;
    int  base, res;
    f    = 8.17580 * (2.0 ** (real'(note % 12) / 12.0));
    base = $rtoi(1.0e6 / (2.0 * f) + 0.5);
    res  = base / (2 ** (note / 12));
    if (res > (2 ** bw) - 1) res = (2 ** bw) - 1;
    return res;
  endfunction

  function automatic int cnt16_of(input int k);
    return int'(if16.cnt_o[k*16 +: 16]);
  endfunction

  function automatic int cnt12_of(input int k);
    return int'(if12.cnt_o[k*12 +: 12]);
  endfunction

  task automatic check_all(input string tag);
    for (int k = 0; k < CH; k++) begin
      chk($sformatf("%s_cnt16_ch%0d", tag, k), cnt16_of(k), m_cnt16[k]);
      chk($sformatf("%s_cnt12_ch%0d", tag, k), cnt12_of(k), m_cnt12[k]);
      chk($sformatf("%s_gate16_ch%0d", tag, k), if16.gate_o[k], m_gate[k]);
      chk($sformatf("%s_gate12_ch%0d", tag, k), if12.gate_o[k], m_gate[k]);
    end
  endtask

  // Presents a request once the block is ready; returns just after the accepting edge.
  task automatic issue(input int note, input int chan);
    int waited = 0;
    while (if16.note_ready_o !== 1'b1 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    chk("ready_before_issue", if16.note_ready_o, 1);
    if16.note_i       = 8'(note);
    if16.chan_i       = CH_BW'(chan);
    if16.note_valid_i = 1'b1;
    @(posedge clk);
  endtask

  // Follows an accepted in-range request to its update and checks everything visible there.
  task automatic finish(input int note, input int chan, input bit hold);
    int exp_lat, lat;
    bit off;
    off     = (note >= 128);
    exp_lat = off ? 2 : ((note % 128) / 12 + 5);
    lat     = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      lat++;
      if (lat == 1 && !hold) if16.note_valid_i = 1'b0;
      if (if16.upd_o === 1'b1) break;
      chk("ready_busy", if16.note_ready_o, 0);
      chk("upd12_quiet", if12.upd_o, 0);
    end
    if (hold) if16.note_valid_i = 1'b0;
    chk("latency", lat, exp_lat);
    chk("upd16", if16.upd_o, 1);
    chk("upd12", if12.upd_o, 1);
    chk("upd_ch16", if16.upd_ch_o, chan);
    chk("upd_ch12", if12.upd_ch_o, chan);
    chk("ready_at_upd", if16.note_ready_o, 1);
    if (off) begin
      m_cnt16[chan] = 0;
      m_cnt12[chan] = 0;
      m_gate[chan]  = 0;
    end else begin
      m_cnt16[chan] = model_count(note % 128, 16);
      m_cnt12[chan] = model_count(note % 128, 12);
      m_gate[chan]  = 1;
    end
    check_all($sformatf("n%0d_c%0d", note, chan));
    $display("[TB] note=0x%02h ch=%0d lat=%0d cnt16=%0d cnt12=%0d gate=%0b",
             note, chan, lat, cnt16_of(chan), cnt12_of(chan), if16.gate_o[chan]);
  endtask

  // Expects no update strobe for n cycles.
  task automatic quiet(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk(tag, if16.upd_o, 0);
    end
  endtask

  task automatic clear_model();
    for (int k = 0; k < CH; k++) begin
      m_cnt16[k] = 0;
      m_cnt12[k] = 0;
      m_gate[k]  = 0;
    end
  endtask

  initial begin
    int n, c;
    clear_model();

    // Reset with a request pending on ch0: it must be ignored.
    if16.note_valid_i = 1'b1;
    if16.note_i       = 8'd60;
    if16.chan_i       = '0;
    repeat (3) @(negedge clk);
    if16.note_valid_i = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", if16.note_ready_o, 1);
    chk("rst_upd", if16.upd_o, 0);
    chk("rst_upd_ch", if16.upd_ch_o, 0);
    check_all("rst");
    quiet("rst_quiet", 12);
    $display("[TB] reset done");

    // Directed conversions with known results.
    issue(69, 2);  finish(69, 2, 0);
    chk("n69_abs", cnt16_of(2), 1136);
    quiet("q1", 2);
    issue(60, 0);  finish(60, 0, 0);
    chk("n60_abs", cnt16_of(0), 1911);
    quiet("q2", 2);
    issue(0, 1);   finish(0, 1, 0);
    chk("n0_abs16", cnt16_of(1), 61156);
    chk("n0_sat12", cnt12_of(1), 4095);
    quiet("q3", 2);
    issue(127, 0); finish(127, 0, 0);
    chk("n127_abs", cnt16_of(0), 39);
    quiet("q4", 2);
    issue(48, 1);  finish(48, 1, 0);
    chk("n48_abs12", cnt12_of(1), 3822);
    quiet("q5", 2);

    // Note-off after note-on on ch1.
    issue(69, 1);  finish(69, 1, 0);
    issue(8'h80, 1); finish(8'h80, 1, 0);
    chk("off_abs", cnt16_of(1), 0);
    quiet("q6", 2);

    // Valid held high through a whole conversion: one acceptance only.
    issue(64, 0);  finish(64, 0, 1);
    quiet("hold_single", 12);

    // Out-of-range channel is dropped.
    issue(40, CH);
    if16.note_valid_i = 1'b0;
    @(negedge clk);
    chk("drop_ready", if16.note_ready_o, 1);
    chk("drop_upd", if16.upd_o, 0);
    quiet("drop_quiet", 10);
    check_all("drop");
    $display("[TB] dropped request on ch%0d", CH);

    // Back-to-back: next request accepted in the update cycle.
    issue(50, 2);  finish(50, 2, 0);
    issue(51, 0);  finish(51, 0, 0);
    quiet("q7", 2);

    // Randomized requests, including note-offs and dropped channels.
    for (int i = 0; i < 25; i++) begin
      n = $urandom_range(0, 255);
      c = $urandom_range(0, CH);
      if (c == CH) begin
        issue(n, c);
        if16.note_valid_i = 1'b0;
        quiet("rnd_drop", 3);
        check_all("rnd_drop");
        $display("[TB] rnd note=0x%02h ch=%0d dropped", n, c);
      end else begin
        issue(n, c);
        finish(n, c, 0);
      end
    end

    // Reset during the divide phase of note 127.
    issue(127, 2);
    if16.note_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    clear_model();
    chk("abort_upd", if16.upd_o, 0);
    chk("abort_upd_ch", if16.upd_ch_o, 0);
    check_all("abort");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ready", if16.note_ready_o, 1);
    quiet("abort_quiet", 15);
    check_all("abort_after");
    $display("[TB] reset during conversion");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/note2cnt_mc.md
# note2cnt_mc

Multi-channel, parametrised successor to the single-voice note-to-count converter. It accepts MIDI note requests for up to CH voices over a valid/ready handshake and converts each note into a half-period counter reload value for the square-wave oscillators. Conversion uses a 12-entry base table at elaboration-time clock rate, an iterative divide-by-12 and an octave shift with saturation. It sits between the note sequencer/MIDI decoder and the per-voice oscillator counters; each voice's count is held until it is rewritten.

## Interface

Parameters:
- BW, 16, width of each half-period count.
- CH, 4, number of voices (1..16).
- CH_BW, 2, channel index width; must be at least clog2(CH), minimum 1.
- CLK_HZ, 1_000_000, system clock frequency used to build the base table.

Ports:
- clk_i  in  1  system clock; all state changes on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- note_valid_i  in  1  request valid.
- note_ready_o  out  1  block can accept a request.
- note_i  in  8  bit 7 = note-off; bits 6:0 = MIDI note 0..127.
- chan_i  in  CH_BW  target voice.
- cnt_o  out  CH*BW  per-voice half-period count; voice k at [k*BW +: BW].
- gate_o  out  CH  per-voice active flag.
- upd_o  out  1  one-cycle pulse when a voice's cnt_o/gate_o changed.
- upd_ch_o  out  CH_BW  voice index qualified by upd_o.

## Operation

- Base table entry k, for k = 0..11: base[k] = round(CLK_HZ / (2 * 8.17580 * 2^(k/12))).
  - Computed at elaboration.
  - Stored internally at 24 bits.
- Result = base[note mod 12] >> (note / 12), floored. If the result exceeds 2^BW-1, it saturates to 2^BW-1.
- Note-off (note_i[7]=1): the voice's cnt_o is set to 0 and its gate_o to 0. Bits 6:0 are ignored.
- Note-on: cnt_o is set to the result and gate_o to 1.
- FSM states: IDLE, DIV, LUT, SHIFT, WRITE.
  - IDLE: note_ready_o=1. On valid&&ready, capture note and channel.
    - chan_i >= CH: request dropped; stay IDLE.
    - Note-off: go to WRITE.
    - Otherwise: go to DIV.
  - DIV: one cycle per step.
    - If rem >= 12: rem -= 12 and oct += 1.
    - Else: go to LUT.
  - LUT: register base[rem].
  - SHIFT: register saturate(base >> oct).
  - WRITE: write the addressed voice; return to IDLE.
- note_ready_o=0 in every state except IDLE. Requests not accepted are not stored.
- Only the addressed voice's cnt_o and gate_o change. All other voices hold their values.

## Timing

- Reset values: cnt_o all 0, gate_o all 0, upd_o 0, upd_ch_o 0, state IDLE. note_ready_o is 1 in the cycle after reset is released.
- Reset asserted in any state aborts the conversion on the next edge. No partial write occurs, and all voices clear.
- The accepting cycle is T. Let oct = note/12.
  - Note-on: DIV occupies T+1..T+oct+1, LUT T+oct+2, SHIFT T+oct+3, WRITE T+oct+4.
  - The new cnt_o/gate_o, upd_o=1 and upd_ch_o are visible together in cycle T+oct+5. note_ready_o is also 1 in that cycle.
- Note-off: WRITE at T+1. Update and ready are visible at T+2.
- Dropped (out-of-range channel): note_ready_o stays 1. A new request may be accepted at T+1. No upd_o.
- Back-to-back throughput: a new request can be accepted in the same cycle that upd_o of the previous request is asserted.
- upd_o is exactly one cycle wide. upd_ch_o holds its last value when upd_o=0.
- Rewriting a voice with the same value still pulses upd_o.

## Test plan

- Reset, then idle: cnt_o=0, gate_o=0, upd_o=0, note_ready_o=1. A note request on ch0 issued with rst_i=1 is ignored.
- CLK_HZ=1e6, BW=16:
  - Note 69 on ch2 at T gives cnt ch2=1136, gate_o[2]=1, upd_o at T+10, upd_ch_o=2.
  - Note 60 on ch0 gives 1911 at T+10.
  - Note 0 gives 61156 at T+5.
  - Note 127 gives 39 at T+15.
  - Other voices are unchanged throughout.
- BW=12: note 0 gives 4095 (saturated). Note 48 gives 61156>>4 = 3822, not saturated.
- Note-off: after note 69 on ch1, send 0x80 to ch1. cnt ch1=0, gate_o[1]=0, upd_o at T+2. ch2 is untouched.
- Handshake:
  - Hold valid high through a conversion: only one request is accepted, and note_ready_o=0 from T+1 until upd_o.
  - chan_i=CH (out of range) gives no upd_o, and ready=1 at T+1.
- Assert rst_i during DIV of note 127: no upd_o occurs, all outputs read 0 after the reset edge, and ready=1 once reset is released.
